// File: rtl/ps2_zx_keyboard.sv
`default_nettype none
// ============================================================================
// Module   : ps2_zx_keyboard
// Purpose  : PS/2 set-2 receiver decoding make/break codes into the ZX
//            Spectrum 8x5 key matrix, read as active-low columns via A15..A8.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_zx_keyboard #(
  parameter int TIMEOUT    = 4096,
  parameter int PAUSE_SKIP = 7
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic [7:0] addr,
  output logic [4:0] key_data,
  output logic [7:0] byte_out,
  output logic       byte_strobe,
  output logic       frame_err,
  output logic       key_reset,
  output logic       key_nmi
);

  localparam int c_TO_W   = $clog2(TIMEOUT + 1);
  localparam int c_SKIP_W = $clog2(PAUSE_SKIP + 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_t;

  logic [1:0]          r_clk_sync;
  logic [1:0]          r_dat_sync;
  logic                r_clk_prev;
  logic                w_fall;
  logic                w_bit;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_bit_cnt;
  logic [7:0]          r_shift;
  logic                r_parity;
  logic [c_TO_W-1:0]   r_to_cnt;
  logic                w_frame_ok;
  logic                w_frame_bad;
  logic                w_timeout;

  logic [7:0]          r_byte_out;
  logic                r_byte_strobe;
  logic                r_frame_err;

  logic                r_ext;
  logic                r_brk;
  logic [c_SKIP_W-1:0] r_skip;
  logic [7:0][4:0]     r_matrix;
  logic                r_key_reset;
  logic                r_key_nmi;
  logic [5:0]          w_loc;
  logic                w_hit;
  logic [4:0]          w_col_or;

  // Synchronisers idle high so reset never manufactures a falling edge
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[0], ps2_clk};
      r_dat_sync <= {r_dat_sync[0], ps2_data};
      r_clk_prev <= r_clk_sync[1];
    end
  end

  assign w_fall = r_clk_prev & ~r_clk_sync[1];
  assign w_bit  = r_dat_sync[1];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_frame_ok  = 1'b0;
    w_frame_bad = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_fall && !w_bit) begin
          w_state_nxt = ST_RECV;
        end
      end
      ST_RECV: begin
        if (w_fall) begin
          if (r_bit_cnt == 4'd10) begin
            w_state_nxt = ST_IDLE;
            if (w_bit && (^{r_shift, r_parity})) begin
              w_frame_ok = 1'b1;
            end else begin
              w_frame_bad = 1'b1;
            end
          end
        end else if (r_to_cnt == c_TO_W'(TIMEOUT)) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_bit_cnt <= 4'd0;
      r_shift   <= 8'h00;
      r_parity  <= 1'b0;
      r_to_cnt  <= '0;
    end else if (r_state == ST_IDLE) begin
      r_to_cnt <= '0;
      if (w_fall && !w_bit) begin
        r_bit_cnt <= 4'd1;
      end
    end else if (w_fall) begin
      r_to_cnt  <= '0;
      r_bit_cnt <= r_bit_cnt + 4'd1;
      if (r_bit_cnt <= 4'd8) begin
        r_shift <= {w_bit, r_shift[7:1]};
      end else if (r_bit_cnt == 4'd9) begin
        r_parity <= w_bit;
      end
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_byte_out    <= 8'h00;
      r_byte_strobe <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_byte_strobe <= w_frame_ok;
      r_frame_err   <= w_frame_bad | w_timeout;
      if (w_frame_ok) begin
        r_byte_out <= r_shift;
      end
    end
  end

  // Key location {row, column}; column 7 marks an unmapped code
  always_comb begin
    w_loc = {3'd7, 3'd7};
    if (r_ext) begin
      case (r_byte_out)
        8'h5A:        w_loc = {3'd6, 3'd0};
        8'h14, 8'h11: w_loc = {3'd7, 3'd1};
        default:      w_loc = {3'd7, 3'd7};
      endcase
    end else begin
      case (r_byte_out)
        8'h12, 8'h59: w_loc = {3'd0, 3'd0};
        8'h1A:        w_loc = {3'd0, 3'd1};
        8'h22:        w_loc = {3'd0, 3'd2};
        8'h21:        w_loc = {3'd0, 3'd3};
        8'h2A:        w_loc = {3'd0, 3'd4};
        8'h1C:        w_loc = {3'd1, 3'd0};
        8'h1B:        w_loc = {3'd1, 3'd1};
        8'h23:        w_loc = {3'd1, 3'd2};
        8'h2B:        w_loc = {3'd1, 3'd3};
        8'h34:        w_loc = {3'd1, 3'd4};
        8'h15:        w_loc = {3'd2, 3'd0};
        8'h1D:        w_loc = {3'd2, 3'd1};
        8'h24:        w_loc = {3'd2, 3'd2};
        8'h2D:        w_loc = {3'd2, 3'd3};
        8'h2C:        w_loc = {3'd2, 3'd4};
        8'h16:        w_loc = {3'd3, 3'd0};
        8'h1E:        w_loc = {3'd3, 3'd1};
        8'h26:        w_loc = {3'd3, 3'd2};
        8'h25:        w_loc = {3'd3, 3'd3};
        8'h2E:        w_loc = {3'd3, 3'd4};
        8'h45:        w_loc = {3'd4, 3'd0};
        8'h46:        w_loc = {3'd4, 3'd1};
        8'h3E:        w_loc = {3'd4, 3'd2};
        8'h3D:        w_loc = {3'd4, 3'd3};
        8'h36:        w_loc = {3'd4, 3'd4};
        8'h4D:        w_loc = {3'd5, 3'd0};
        8'h44:        w_loc = {3'd5, 3'd1};
        8'h43:        w_loc = {3'd5, 3'd2};
        8'h3C:        w_loc = {3'd5, 3'd3};
        8'h35:        w_loc = {3'd5, 3'd4};
        8'h5A:        w_loc = {3'd6, 3'd0};
        8'h4B:        w_loc = {3'd6, 3'd1};
        8'h42:        w_loc = {3'd6, 3'd2};
        8'h3B:        w_loc = {3'd6, 3'd3};
        8'h33:        w_loc = {3'd6, 3'd4};
        8'h29:        w_loc = {3'd7, 3'd0};
        8'h14, 8'h11: w_loc = {3'd7, 3'd1};
        8'h3A:        w_loc = {3'd7, 3'd2};
        8'h31:        w_loc = {3'd7, 3'd3};
        8'h32:        w_loc = {3'd7, 3'd4};
        default:      w_loc = {3'd7, 3'd7};
      endcase
    end
  end

  assign w_hit = (w_loc[2:0] != 3'd7);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_ext       <= 1'b0;
      r_brk       <= 1'b0;
      r_skip      <= '0;
      r_matrix    <= '0;
      r_key_reset <= 1'b0;
      r_key_nmi   <= 1'b0;
    end else if (r_byte_strobe) begin
      if (r_skip != '0) begin
        r_skip <= r_skip - 1'b1;
      end else if (r_byte_out == 8'hE1) begin
        r_skip <= c_SKIP_W'(PAUSE_SKIP);
      end else if (r_byte_out == 8'hE0) begin
        r_ext <= 1'b1;
      end else if (r_byte_out == 8'hF0) begin
        r_brk <= 1'b1;
      end else begin
        if (w_hit) begin
          r_matrix[w_loc[5:3]][w_loc[2:0]] <= ~r_brk;
        end
        if (!r_ext && r_byte_out == 8'h07) begin
          r_key_reset <= ~r_brk;
        end
        if (!r_ext && r_byte_out == 8'h78) begin
          r_key_nmi <= ~r_brk;
        end
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end
    end
  end

  // Any row whose address bit is low contributes its pressed keys
  always_comb begin
    w_col_or = 5'b00000;
    for (int r = 0; r < 8; r++) begin
      if (!addr[r]) begin
        w_col_or = w_col_or | r_matrix[r];
      end
    end
  end

  assign key_data    = ~w_col_or;
  assign byte_out    = r_byte_out;
  assign byte_strobe = r_byte_strobe;
  assign frame_err   = r_frame_err;
  assign key_reset   = r_key_reset;
  assign key_nmi     = r_key_nmi;

endmodule
`default_nettype wire

// File: tb/tb_ps2_zx_keyboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_zx_keyboard
// Purpose  : Self-checking bench driving PS/2 frames against a byte-level
//            keyboard model of the ZX matrix decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_zx_keyboard;

  localparam int TIMEOUT    = 4096;
  localparam int PAUSE_SKIP = 7;
  localparam int HALF       = 6;

  logic       clk_sys  = 1'b0;
  logic       reset_n  = 1'b0;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] addr     = 8'hFF;
  logic [4:0] key_data;
  logic [7:0] byte_out;
  logic       byte_strobe;
  logic       frame_err;
  logic       key_reset;
  logic       key_nmi;

  always #5 clk_sys = ~clk_sys;

  ps2_zx_keyboard #(.TIMEOUT(TIMEOUT), .PAUSE_SKIP(PAUSE_SKIP)) u_dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .addr        (addr),
    .key_data    (key_data),
    .byte_out    (byte_out),
    .byte_strobe (byte_strobe),
    .frame_err   (frame_err),
    .key_reset   (key_reset),
    .key_nmi     (key_nmi)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  int n_strobe = 0;
  int n_err    = 0;
  always @(negedge clk_sys) begin
    if (byte_strobe === 1'b1) n_strobe++;
    if (frame_err === 1'b1) n_err++;
  end

  // Keyboard model: row-major table of key codes, bit 0 first in each row
  logic [7:0] key_tab [0:7][0:4] = '{
    '{8'h12, 8'h1A, 8'h22, 8'h21, 8'h2A},
    '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34},
    '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C},
    '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E},
    '{8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36},
    '{8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35},
    '{8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33},
    '{8'h29, 8'h14, 8'h3A, 8'h31, 8'h32}
  };
  logic [4:0] m_mat [0:7];
  bit         m_ext, m_brk, m_rst, m_nmi;
  int         m_skip;

  task automatic model_reset();
    for (int r = 0; r < 8; r++) m_mat[r] = 5'b0;
    m_ext = 0; m_brk = 0; m_rst = 0; m_nmi = 0; m_skip = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int row, col;
    row = -1; col = -1;
    if (m_skip > 0) begin
      m_skip--;
    end else if (b == 8'hE1) begin
      m_skip = PAUSE_SKIP;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      if (m_ext) begin
        if (b == 8'h5A) begin row = 6; col = 0; end
        if (b == 8'h14 || b == 8'h11) begin row = 7; col = 1; end
      end else begin
        for (int r = 0; r < 8; r++)
          for (int c = 0; c < 5; c++)
            if (key_tab[r][c] == b) begin row = r; col = c; end
        if (b == 8'h59) begin row = 0; col = 0; end
        if (b == 8'h11) begin row = 7; col = 1; end
        if (b == 8'h07) m_rst = !m_brk;
        if (b == 8'h78) m_nmi = !m_brk;
      end
      if (row >= 0) m_mat[row][col] = !m_brk;
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  function automatic logic [4:0] exp_kd(input logic [7:0] a);
    logic [4:0] acc;
    acc = 5'b0;
    for (int r = 0; r < 8; r++) if (!a[r]) acc = acc | m_mat[r];
    return ~acc;
  endfunction

  // Drive nbits of an 11-bit frame: start, data LSB first, parity, stop
  task automatic ps2_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk_sys);
      ps2_data = f[i];
      repeat (HALF) @(negedge clk_sys);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk_sys);
      ps2_clk = 1'b1;
    end
    @(negedge clk_sys);
    ps2_data = 1'b1;
    repeat (8) @(negedge clk_sys);
  endtask

  task automatic send_byte(input logic [7:0] b);
    ps2_frame(b, 1'b0, 1'b0, 11);
    model_byte(b);
  endtask

  task automatic send_checked(input string tag, input logic [7:0] b);
    int s0;
    s0 = n_strobe;
    send_byte(b);
    check_eq({tag, "_strobes"}, n_strobe - s0, 1);
    check_eq({tag, "_byte"}, byte_out, b);
  endtask

  task automatic read_kd(input string tag, input logic [7:0] a, input logic [4:0] exp);
    @(negedge clk_sys);
    addr = a;
    #2;
    check_eq(tag, key_data, exp);
    check_eq({tag, "_model"}, key_data, exp_kd(a));
  endtask

  logic [7:0] pool [0:14] = '{8'h12, 8'h59, 8'h1A, 8'h1C, 8'h2C, 8'h3D, 8'h44,
                              8'h5A, 8'h29, 8'h14, 8'h11, 8'h32, 8'h0E, 8'h07, 8'h78};

  initial begin
    int s0, e0;
    logic [7:0] code, ra;
    model_reset();
    repeat (5) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_sys);

    addr = 8'h00; #2;
    check_eq("rst_key_data", key_data, 5'h1F);
    check_eq("rst_byte_out", byte_out, 8'h00);
    check_eq("rst_strobe", byte_strobe, 1'b0);
    check_eq("rst_frame_err", frame_err, 1'b0);
    check_eq("rst_key_reset", key_reset, 1'b0);
    check_eq("rst_key_nmi", key_nmi, 1'b0);

    send_checked("make_A", 8'h1C);
    read_kd("kd_A", 8'hFD, 5'h1E);
    send_checked("brk_pfx", 8'hF0);
    send_checked("brk_A", 8'h1C);
    read_kd("kd_A_rel", 8'hFD, 5'h1F);

    send_byte(8'h12);
    send_byte(8'h1A);
    read_kd("kd_capsz_fe", 8'hFE, 5'h1C);
    read_kd("kd_capsz_00", 8'h00, 5'h1C);
    read_kd("kd_capsz_ff", 8'hFF, 5'h1F);
    send_byte(8'hF0); send_byte(8'h12);
    send_byte(8'hF0); send_byte(8'h1A);

    s0 = n_strobe; e0 = n_err;
    ps2_frame(8'h1C, 1'b1, 1'b0, 11);
    check_eq("par_err", n_err - e0, 1);
    check_eq("par_nostrobe", n_strobe - s0, 0);
    read_kd("par_kd", 8'hFD, 5'h1F);
    s0 = n_strobe; e0 = n_err;
    ps2_frame(8'h1C, 1'b0, 1'b1, 11);
    check_eq("stop_err", n_err - e0, 1);
    check_eq("stop_nostrobe", n_strobe - s0, 0);
    read_kd("stop_kd", 8'hFD, 5'h1F);

    s0 = n_strobe; e0 = n_err;
    ps2_frame(8'h29, 1'b0, 1'b0, 4);
    repeat (TIMEOUT + 50) @(negedge clk_sys);
    check_eq("to_err", n_err - e0, 1);
    check_eq("to_nostrobe", n_strobe - s0, 0);
    send_checked("after_to", 8'h29);
    read_kd("kd_space", 8'h7F, 5'h1E);
    send_byte(8'hF0); send_byte(8'h29);

    send_byte(8'hE0); send_byte(8'h5A);
    read_kd("kd_kp_enter", 8'hBF, 5'h1E);
    send_byte(8'hE0); send_byte(8'h12);
    read_kd("kd_fake_shift", 8'hFE, 5'h1F);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h5A);
    read_kd("kd_enter_rel", 8'hBF, 5'h1F);
    send_byte(8'hE1);
    send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
    send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
    read_kd("kd_pause_sym", 8'h7F, 5'h1F);
    send_byte(8'h1C);
    read_kd("kd_after_pause", 8'hFD, 5'h1E);
    send_byte(8'hF0); send_byte(8'h1C);

    send_byte(8'h07);
    check_eq("f12_make", key_reset, 1'b1);
    send_byte(8'hF0); send_byte(8'h07);
    check_eq("f12_brk", key_reset, 1'b0);
    send_byte(8'h78);
    check_eq("f11_make", key_nmi, 1'b1);
    send_byte(8'hF0); send_byte(8'h78);
    check_eq("f11_brk", key_nmi, 1'b0);

    for (int it = 0; it < 30; it++) begin
      code = pool[$urandom_range(0, 14)];
      if ($urandom_range(0, 4) == 0) send_byte(8'hE0);
      if ($urandom_range(0, 1) == 1) send_byte(8'hF0);
      send_checked("rnd", code);
      ra = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 255)) : ~(8'h01 << $urandom_range(0, 7));
      @(negedge clk_sys);
      addr = ra;
      #2;
      check_eq("rnd_kd", key_data, exp_kd(ra));
      check_eq("rnd_key_reset", key_reset, m_rst);
      check_eq("rnd_key_nmi", key_nmi, m_nmi);
    end

    send_byte(8'h07);
    send_byte(8'h1C);
    ps2_frame(8'h1C, 1'b0, 1'b0, 6);
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_sys);
    addr = 8'h00; #2;
    check_eq("mid_rst_kd", key_data, 5'h1F);
    check_eq("mid_rst_byte", byte_out, 8'h00);
    check_eq("mid_rst_key_reset", key_reset, 1'b0);
    check_eq("mid_rst_key_nmi", key_nmi, 1'b0);
    send_checked("post_rst", 8'h1C);
    read_kd("post_rst_kd", 8'hFD, 5'h1E);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
